// File: rtl/apb_xfer_arbiter.sv
// Round-robin arbiter sharing one APB master port between NUM_REQ requesters.
// Sequences SETUP/ACCESS, decodes Pselx from the address and returns tagged responses.
module apb_xfer_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ-1:0]          req_write,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]           rsp_rdata,
    output logic                        rsp_err,
    output logic [ADDR_W-1:0]           Paddr,
    output logic                        Pwrite,
    output logic [DATA_W-1:0]           Pwdata,
    output logic [3:0]                  Pselx,
    output logic                        Penable,
    input  logic [DATA_W-1:0]           Prdata
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_ERR    = 2'd3;

    logic [1:0]          r_state;
    logic [PTR_W-1:0]    r_ptr;
    logic [NUM_REQ-1:0]  r_id_oh;
    logic [ADDR_W-1:0]   r_paddr;
    logic                r_pwrite;
    logic [DATA_W-1:0]   r_pwdata;
    logic [3:0]          r_psel;
    logic                r_penable;
    logic [NUM_REQ-1:0]  r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic                r_rsp_err;

    logic                w_hi_found;
    logic                w_lo_found;
    logic [PTR_W-1:0]    w_hi_idx;
    logic [PTR_W-1:0]    w_lo_idx;
    logic [NUM_REQ-1:0]  w_hi_oh;
    logic [NUM_REQ-1:0]  w_lo_oh;
    logic [PTR_W-1:0]    w_gnt_idx;
    logic [NUM_REQ-1:0]  w_gnt_oh;
    logic                w_arb_en;
    logic                w_grant;
    logic [ADDR_W-1:0]   w_gnt_addr;
    logic                w_gnt_write;
    logic [DATA_W-1:0]   w_gnt_wdata;

    function automatic logic f_in_range(input logic [ADDR_W-1:0] addr);
        return (addr[31:26] == 6'b100000);
    endfunction

    function automatic logic [3:0] f_decode_sel(input logic [ADDR_W-1:0] addr);
        return 4'b0001 << addr[25:24];
    endfunction

    // Round robin: lowest valid index above the pointer wins, else lowest valid overall.
    always_comb begin
        w_hi_found = 1'b0;
        w_lo_found = 1'b0;
        w_hi_idx   = '0;
        w_lo_idx   = '0;
        w_hi_oh    = '0;
        w_lo_oh    = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (req_valid[j]) begin
                if (!w_hi_found && (j > int'(r_ptr))) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = PTR_W'(j);
                    w_hi_oh[j] = 1'b1;
                end
                if (!w_lo_found) begin
                    w_lo_found = 1'b1;
                    w_lo_idx   = PTR_W'(j);
                    w_lo_oh[j] = 1'b1;
                end
            end
        end
        w_gnt_idx = w_hi_found ? w_hi_idx : w_lo_idx;
        w_gnt_oh  = w_hi_found ? w_hi_oh  : w_lo_oh;
    end

    always_comb begin
        w_gnt_addr  = '0;
        w_gnt_write = 1'b0;
        w_gnt_wdata = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (w_gnt_oh[j]) begin
                w_gnt_addr  = req_addr[j*ADDR_W +: ADDR_W];
                w_gnt_write = req_write[j];
                w_gnt_wdata = req_wdata[j*DATA_W +: DATA_W];
            end
        end
    end

    assign w_arb_en  = (r_state == S_IDLE) || (r_state == S_ACCESS);
    assign w_grant   = w_arb_en && (w_hi_found || w_lo_found);
    assign req_ready = (w_grant && !reset) ? w_gnt_oh : '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_ptr       <= PTR_W'(NUM_REQ - 1);
            r_id_oh     <= '0;
            r_paddr     <= '0;
            r_pwrite    <= 1'b0;
            r_pwdata    <= '0;
            r_psel      <= '0;
            r_penable   <= 1'b0;
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            case (r_state)
                S_SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= S_ACCESS;
                end
                S_ERR: begin
                    r_rsp_valid <= r_id_oh;
                    r_rsp_err   <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: begin
                    // ACCESS retires its transfer on the same edge that may launch the next.
                    if (r_state == S_ACCESS) begin
                        r_rsp_valid <= r_id_oh;
                        r_rsp_rdata <= r_pwrite ? '0 : Prdata;
                    end
                    r_penable <= 1'b0;
                    if (w_grant) begin
                        r_ptr   <= w_gnt_idx;
                        r_id_oh <= w_gnt_oh;
                        if (f_in_range(w_gnt_addr)) begin
                            r_paddr  <= w_gnt_addr;
                            r_pwrite <= w_gnt_write;
                            r_pwdata <= w_gnt_wdata;
                            r_psel   <= f_decode_sel(w_gnt_addr);
                            r_state  <= S_SETUP;
                        end else begin
                            r_psel  <= '0;
                            r_state <= S_ERR;
                        end
                    end else begin
                        r_psel  <= '0;
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign Paddr     = r_paddr;
    assign Pwrite    = r_pwrite;
    assign Pwdata    = r_pwdata;
    assign Pselx     = r_psel;
    assign Penable   = r_penable;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule
